logic_unit_pipe: RTL

- Parametrised, pipelined bitwise logic unit and successor to the single-bit combinational gate set.
- Applies one of seven gate operations (NOT, AND, OR, NAND, NOR, XOR, XNOR) across WIDTH-bit operands, selected per beat by opcode.
- Input and output use valid/ready handshakes, with a 2-stage registered pipeline.
- Adds an accumulate mode (operand b replaced by the previous result) and result status flags.
- Sits between a register-file/stimulus source and a downstream consumer.

---
 rtl/logic_unit_pipe_if.sv | 34 +++
 rtl/logic_unit_pipe.sv | 139 +++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - handshake bundle for the pipelined logic unit
//
// Groups the input beat (in_valid/in_ready, operands, opcode, accumulator
// controls) and the output beat (out_valid/out_ready, result and flags).
//   master : stimulus / consumer side (drives operands and out_ready)
//   slave  : logic unit side (drives in_ready, result and flags)
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic             all_ones;
    logic             err;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, parity, all_ones, err
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, parity, all_ones, err
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined WIDTH-bit gate unit with accumulator
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : logic_unit_pipe_if.slave
//            in_valid/in_ready/a/b/op/acc_en/acc_clr  input beat
//            out_valid/out_ready/y/zero/parity/all_ones/err  output beat
//
// op: 0 NOT(a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal (y=0, err=1)
module logic_unit_pipe #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    // Stage-1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_r;
    logic             s1_err;

    // Stage-2 (output) state
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             parity_q;
    logic             all_ones_q;
    logic             err_q;

    logic [WIDTH-1:0] acc_q;

    // Flow control
    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    // Combinational gate evaluation
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] r;
    logic             r_err;

    // in_ready depends on out_ready but never on in_valid, so upstream
    // may wait for in_ready before raising in_valid without deadlock.
    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !s1_valid || s2_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.all_ones  = all_ones_q;
    assign bus.err       = err_q;

    always_comb begin
        b_eff = bus.acc_en ? acc_q : bus.b;
        r     = '0;
        r_err = 1'b0;
        case (op_e'(bus.op))
            OP_NOT:  r = ~bus.a;
            OP_AND:  r = bus.a & b_eff;
            OP_OR:   r = bus.a | b_eff;
            OP_NAND: r = ~(bus.a & b_eff);
            OP_NOR:  r = ~(bus.a | b_eff);
            OP_XOR:  r = bus.a ^ b_eff;
            OP_XNOR: r = ~(bus.a ^ b_eff);
            default: begin
                r     = '0;
                r_err = 1'b1;
            end
        endcase
    end

    // Stage 1: capture on every input transfer; empties when it hands
    // its beat to stage 2 without a new beat arriving behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_err   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_r     <= r;
            s1_err   <= r_err;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: flags are derived from the value being loaded so they
    // always travel with the y they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            all_ones_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                y_q        <= s1_r;
                err_q      <= s1_err;
                zero_q     <= (s1_r == '0);
                parity_q   <= ^s1_r;
                all_ones_q <= &s1_r;
            end
        end
    end

    // Accumulator: clear has priority; a beat arriving with clear still
    // used the old value through b_eff above. Illegal ops leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= ACC_INIT;
        end else if (bus.acc_clr) begin
            acc_q <= ACC_INIT;
        end else if (in_fire && !r_err) begin
            acc_q <= r;
        end
    end

endmodule
